ssm_bitfetch: RTL
=================

# ssm_bitfetch

Bitstream fetch buffer between the slice bitstream source and the four substream parsers (ssm0 parser plus three ssm1–3 parsers) of the VDC-M decoder. It accepts 128-bit mux words over a valid/ready stream, holds them in a circular prefetch buffer, and serves up to four parser read requests per cycle in ascending substream order, with zero-latency combinational data return. It replaces bench-side address bookkeeping with synthesizable RTL and adds occupancy, underflow and pop-count status.

## Interface
- DW, 128, mux word width
- DEPTH, 8, buffer words; power of two, ≥4
- CNTW, 16, pop counter width

- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- flush  in  1  slice restart; clears buffer state
- in_data  in  DW  incoming mux word
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer can accept a word
- rd_en  in  4  bit i = substream i requests one word this cycle
- out_data  out  4*DW  slice [i*DW +: DW] = word for substream i
- buf_rdy  out  1  occupancy ≥ 4 (a full 4-way read is safe)
- occupancy  out  $clog2(DEPTH)+1  words held
- underflow  out  1  sticky: a request found no word
- pop_cnt  out  CNTW  total words delivered since rst/flush, wraps

## Operation
- Storage: DEPTH×DW array; wr_ptr, rd_ptr are $clog2(DEPTH)+1 bits; occupancy = wr_ptr − rd_ptr.
- Push: in_valid && in_ready writes mem[wr_ptr], wr_ptr+1. in_ready = occupancy < DEPTH. Same-cycle pops give no credit to in_ready.
- Rank: r_i = popcount(rd_en[i-1:0]). Substreams are served in order 0→3.
- Read: out_data[i] = mem[rd_ptr + r_i] when rd_en[i] && r_i < occupancy; otherwise 0.
- Pop: k = popcount(rd_en), pops = min(k, occupancy); rd_ptr += pops; pop_cnt += pops (mod 2^CNTW).
- Underflow: if k > occupancy, the starved substreams (highest ranks) receive 0, and underflow sets the next cycle. It is cleared only by rst.
- Simultaneous push and pop: occupancy_next = occupancy + push − pops. A word pushed in cycle n is readable from cycle n+1 only (no bypass).
- flush: on the next edge, pointers and pop_cnt become 0. The same-cycle push and pops are discarded. underflow is kept. flush has priority over push and pop.
- rst: highest priority. Same effect as flush, and also clears underflow.

## Timing
- Values after the reset edge: occupancy=0, in_ready=1, buf_rdy=0, underflow=0, pop_cnt=0, out_data=0. Memory contents are not reset.
- rd_en→out_data: combinational, 0 cycles. Parsers sample in the same cycle they assert rd_en.
- Push→visible: 1 cycle. Pop→occupancy/in_ready/buf_rdy update: 1 cycle.
- in_ready, buf_rdy and occupancy are decoded from registered pointers only. They do not depend combinationally on in_valid or rd_en.
- Pointer wrap: the low bits index memory and the MSB disambiguates full from empty. Full means occupancy = DEPTH (MSB differs, low bits equal).
- rst or flush asserted mid-transfer: the in-flight handshake is dropped. The source must re-send from the slice start.

## Structure
- Shared package vdcm_pkg: SSM_NUM=4, MUX_WORD_W=128. Reuse it from the parser blocks.
- Sub-module ssm_fetch_mem holds the storage array: 1 synchronous write port, 4 combinational read ports. Rank, pop and counter logic stay in ssm_bitfetch.

## Test plan
- Reset, then push words W0..W7 (W_n = 128'h n) with rd_en=0 → occupancy=8, in_ready=0, buf_rdy=1. A ninth in_valid is not accepted.
- From full, rd_en=4'b1111 → out_data slices = W0,W1,W2,W3 in the same cycle. Next cycle occupancy=4, pop_cnt=4.
- rd_en=4'b1010 with W4 at the head → ssm1 gets W4, ssm3 gets W5, ssm0 and ssm2 get 0. rd_ptr advances by 2.
- occupancy=2, rd_en=4'b1111 → ssm0 and ssm1 get data, ssm2 and ssm3 get 0. Next cycle underflow=1, occupancy=0, pop_cnt += 2. underflow stays 1 through flush and clears only on rst.
- Push and a 1-word pop in the same cycle at occupancy=3 → occupancy=3 next cycle. The pushed word is not returned that cycle. Run a 10,000-word random stream and check pointer wrap and in-order delivery against a scoreboard.
- flush with in_valid=1 and rd_en=4'b0001 in the same cycle → next cycle occupancy=0 and pop_cnt=0. The pushed word is discarded and underflow is unchanged.

Source files
------------

// File: rtl/vdcm_pkg.sv
// rtl/vdcm_pkg.sv - shared VDC-M decoder constants, rank type and request popcount
package vdcm_pkg;

    // Substream parsers fed by one bitstream fetch buffer (ssm0 + ssm1..3).
    localparam int SSM_NUM    = 4;
    // Width of one mux word as delivered by the slice bitstream source.
    localparam int MUX_WORD_W = 128;

    // A rank or request count ranges 0..SSM_NUM inclusive.
    localparam int RANK_W = $clog2(SSM_NUM + 1);

    typedef logic [RANK_W-1:0]  rank_t;
    typedef logic [SSM_NUM-1:0] ssm_mask_t;

    // Number of substreams asserting a read request.
    function automatic rank_t popcount_req(input ssm_mask_t req);
        rank_t n;
        n = '0;
        for (int i = 0; i < SSM_NUM; i++) begin
            n = n + rank_t'(req[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ssm_fetch_mem.sv
// rtl/ssm_fetch_mem.sv - prefetch word storage, one synchronous write port, NRD combinational read ports
//
// Ports:
//   clk      clock
//   wr_en    write strobe, mem[wr_addr] <= wr_data on the rising edge
//   wr_addr  write word index
//   wr_data  write word
//   rd_addr  NRD packed read indices, port p at [p*AW +: AW]
//   rd_data  NRD packed read words, port p at [p*DW +: DW], combinational
module ssm_fetch_mem #(
    parameter int DW    = 128,
    parameter int DEPTH = 8,
    parameter int NRD   = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*DW-1:0]   rd_data
);

    // Contents are intentionally not reset; the pointers define what is valid.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign rd_data[p*DW +: DW] = mem[rd_addr[p*AW +: AW]];
    end

endmodule

// File: rtl/ssm_bitfetch.sv
// rtl/ssm_bitfetch.sv - circular mux-word prefetch buffer serving four ranked substream readers
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, clears pointers, pop_cnt and underflow
//   flush      slice restart, clears pointers and pop_cnt, keeps underflow
//   in_data    incoming mux word
//   in_valid   in_data valid
//   in_ready   buffer has room (occupancy < DEPTH)
//   rd_en      bit i: substream i takes one word this cycle
//   out_data   slice [i*DW +: DW] is the word for substream i, 0 when not served
//   buf_rdy    occupancy >= SSM_NUM, a full-width read cannot starve
//   occupancy  words held
//   underflow  sticky, a request found no word
//   pop_cnt    words delivered since rst/flush, wraps
module ssm_bitfetch
    import vdcm_pkg::*;
#(
    parameter int DW    = MUX_WORD_W,
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SSM_NUM-1:0]       rd_en,
    output logic [SSM_NUM*DW-1:0]    out_data,
    output logic                     buf_rdy,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     underflow,
    output logic [CNTW-1:0]          pop_cnt
);

    localparam int AW = $clog2(DEPTH);
    // One extra pointer bit separates full (MSBs differ) from empty.
    localparam int PW = AW + 1;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] pop_cnt_q;
    logic            underflow_q;

    logic [PW-1:0]   occ;
    logic            push;
    rank_t           rank [SSM_NUM];
    rank_t           req_cnt;
    logic [PW-1:0]   req_cnt_w;
    logic [PW-1:0]   pops;
    logic            starve;
    logic [SSM_NUM-1:0]    served;
    logic [SSM_NUM*AW-1:0] rd_addr;
    logic [SSM_NUM*DW-1:0] rd_words;

    // Status comes from registered pointers only, so in_ready/buf_rdy never
    // combinationally depend on in_valid or rd_en.
    assign occ       = wr_ptr - rd_ptr;
    assign occupancy = occ;
    assign in_ready  = (occ < PW'(DEPTH));
    assign buf_rdy   = (occ >= PW'(SSM_NUM));
    assign underflow = underflow_q;
    assign pop_cnt   = pop_cnt_q;

    // Pops in this cycle do not free space for a same-cycle push.
    assign push = in_valid && in_ready;

    // Rank of substream i = number of lower-numbered requesters; it selects
    // which word past the head that substream receives.
    always_comb begin
        rank_t acc;
        acc = '0;
        for (int i = 0; i < SSM_NUM; i++) begin
            rank[i] = acc;
            acc     = acc + rank_t'(rd_en[i]);
        end
    end

    assign req_cnt   = popcount_req(rd_en);
    assign req_cnt_w = PW'(req_cnt);

    // Highest ranks starve first when fewer words are held than requested.
    assign starve = (req_cnt_w > occ);
    assign pops   = starve ? occ : req_cnt_w;

    always_comb begin
        rd_addr = '0;
        served  = '0;
        for (int i = 0; i < SSM_NUM; i++) begin
            rd_addr[i*AW +: AW] = rd_ptr[AW-1:0] + AW'(rank[i]);
            served[i]           = rd_en[i] && (PW'(rank[i]) < occ);
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < SSM_NUM; i++) begin
            if (served[i]) begin
                out_data[i*DW +: DW] = rd_words[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pop_cnt_q   <= '0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            // Slice restart: in-flight push and pops are dropped.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_ptr + pops;
            pop_cnt_q <= pop_cnt_q + CNTW'(pops);
            if (starve) begin
                underflow_q <= 1'b1;
            end
        end
    end

    ssm_fetch_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .NRD   (SSM_NUM),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push && !flush && !rst),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_words)
    );

endmodule
